// File: rtl/traffic_input_cond.sv
// Input conditioning for fsm_traffic: sync, debounce, walk latch, 1 Hz tick.
// Define SENSOR_DEBOUNCE_EN to debounce the sensor path as well as walk.
module traffic_input_cond #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int DB_CYCLES = 500_000
) (
  input  logic clock,
  input  logic rst,
  input  logic walk_btn,
  input  logic sensor_in,
  input  logic walk_ack,
  output logic walk_req,
  output logic sensor,
  output logic tick_1hz
);

  localparam int DBW =
    (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [DBW-1:0] DB_MAX =
    DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] TICK_MAX =
    TW'(TICK_DIV - 1);

  logic           walk_s1;
  logic           walk_s2;
  logic           walk_db;
  logic           walk_db_q;
  logic [DBW-1:0] walk_cnt;
  logic           walk_rise;
  logic           sensor_s1;
  logic           sensor_s2;
  logic [TW-1:0]  tick_cnt;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      walk_s1  <= 1'b0;
      walk_s2  <= 1'b0;
      walk_db  <= 1'b0;
      walk_cnt <= '0;
    end else begin
      walk_s1 <= walk_btn;
      walk_s2 <= walk_s1;
      if (walk_s2 == walk_db) begin
        walk_cnt <= '0;
      end else if (walk_cnt == DB_MAX) begin
        walk_db  <= walk_s2;
        walk_cnt <= '0;
      end else begin
        walk_cnt <= walk_cnt + DBW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sensor_s1 <= 1'b0;
      sensor_s2 <= 1'b0;
    end else begin
      sensor_s1 <= sensor_in;
      sensor_s2 <= sensor_s1;
    end
  end

`ifdef SENSOR_DEBOUNCE_EN
  logic           sensor_db;
  logic [DBW-1:0] sensor_cnt;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sensor_db  <= 1'b0;
      sensor_cnt <= '0;
    end else if (sensor_s2 == sensor_db) begin
      sensor_cnt <= '0;
    end else if (sensor_cnt == DB_MAX) begin
      sensor_db  <= sensor_s2;
      sensor_cnt <= '0;
    end else begin
      sensor_cnt <= sensor_cnt + DBW'(1);
    end
  end

  assign sensor = sensor_db;
`else
  assign sensor = sensor_s2;
`endif

  // A new press must win over a same-cycle ack
  assign walk_rise = walk_db & ~walk_db_q;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      walk_db_q <= 1'b0;
      walk_req  <= 1'b0;
    end else begin
      walk_db_q <= walk_db;
      walk_req  <= walk_rise | (walk_req & ~walk_ack);
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      tick_1hz <= 1'b0;
    end else begin
      tick_1hz <= (tick_cnt == TICK_MAX);
      if (tick_cnt == TICK_MAX) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_traffic_input_cond.sv
// Scoreboard bench for traffic_input_cond (TICK_DIV=10, DB_CYCLES=4).
// Expected output events are queued by stimulus, matched by a monitor.
module tb_traffic_input_cond;

  typedef struct {
    logic v;
    int   c;
  } ev_t;

  logic clock = 1'b0;
  logic rst;
  logic walk_btn;
  logic sensor_in;
  logic walk_ack;
  logic walk_req;
  logic sensor;
  logic tick_1hz;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   tick_next = 10;
  int   h;
  bit   mon_en = 1'b0;
  logic p_walk = 1'b0;
  logic p_sens = 1'b0;

  int   tq[$];
  ev_t  wq[$];
  ev_t  sq[$];

  traffic_input_cond #(
    .TICK_DIV(10),
    .DB_CYCLES(4)
  ) dut (
    .clock(clock),
    .rst(rst),
    .walk_btn(walk_btn),
    .sensor_in(sensor_in),
    .walk_ack(walk_ack),
    .walk_req(walk_req),
    .sensor(sensor),
    .tick_1hz(tick_1hz)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge rst) begin
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic check(input string nm,
                       input logic got,
                       input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nm, got, want);
    end
  endtask

  task automatic run(input int n);
    while (tick_next <= cyc + n) begin
      tq.push_back(tick_next);
      tick_next += 10;
    end
    repeat (n) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (tick_1hz) begin
        total++;
        if (tq.size() == 0) begin
          bad++;
          $display("FAIL tick: unexpected at cyc %0d", cyc);
        end else begin
          int e;
          e = tq.pop_front();
          if (e != cyc) begin
            bad++;
            $display("FAIL tick: at cyc %0d want cyc %0d",
                     cyc, e);
          end
        end
      end
      if (walk_req !== p_walk) begin
        total++;
        if (wq.size() == 0) begin
          bad++;
          $display("FAIL walk_req: unexpected %0b at cyc %0d",
                   walk_req, cyc);
        end else begin
          ev_t e;
          e = wq.pop_front();
          if (e.v !== walk_req || e.c != cyc) begin
            bad++;
            $display("FAIL walk_req: got %0b@%0d want %0b@%0d",
                     walk_req, cyc, e.v, e.c);
          end
        end
      end
      if (sensor !== p_sens) begin
        total++;
        if (sq.size() == 0) begin
          bad++;
          $display("FAIL sensor: unexpected %0b at cyc %0d",
                   sensor, cyc);
        end else begin
          ev_t e;
          e = sq.pop_front();
          if (e.v !== sensor || e.c != cyc) begin
            bad++;
            $display("FAIL sensor: got %0b@%0d want %0b@%0d",
                     sensor, cyc, e.v, e.c);
          end
        end
      end
      p_walk = walk_req;
      p_sens = sensor;
    end
  end

  initial begin
    rst = 1'b0;
    walk_btn = 1'b0;
    sensor_in = 1'b0;
    walk_ack = 1'b0;
    repeat (3) @(negedge clock);
    check("reset walk_req", walk_req, 1'b0);
    check("reset sensor", sensor, 1'b0);
    check("reset tick", tick_1hz, 1'b0);

    // idle: ticks at 10, 20, 30
    rst = 1'b1;
    p_walk = 1'b0;
    p_sens = 1'b0;
    mon_en = 1'b1;
    run(35);

    // bounce, then hold
    repeat (3) begin
      walk_btn = 1'b1;
      run(2);
      walk_btn = 1'b0;
      run(2);
    end
    walk_btn = 1'b1;
    wq.push_back('{1'b1, cyc + 7});
    run(12);

    // ack while held, then re-arm
    walk_ack = 1'b1;
    wq.push_back('{1'b0, cyc + 1});
    run(1);
    walk_ack = 1'b0;
    run(10);
    walk_btn = 1'b0;
    run(8);
    walk_btn = 1'b1;
    wq.push_back('{1'b1, cyc + 7});
    run(12);

    // set and ack in the same cycle
    walk_ack = 1'b1;
    wq.push_back('{1'b0, cyc + 1});
    run(1);
    walk_ack = 1'b0;
    walk_btn = 1'b0;
    run(8);
    walk_btn = 1'b1;
    wq.push_back('{1'b1, cyc + 7});
    run(6);
    walk_ack = 1'b1;
    run(1);
    walk_ack = 1'b0;
    run(10);
    walk_btn = 1'b0;
    run(8);

    // sensor glitch and level
    sensor_in = 1'b1;
`ifndef SENSOR_DEBOUNCE_EN
    sq.push_back('{1'b1, cyc + 2});
    sq.push_back('{1'b0, cyc + 4});
`endif
    run(2);
    sensor_in = 1'b0;
    run(10);
    sensor_in = 1'b1;
    h = cyc;
`ifdef SENSOR_DEBOUNCE_EN
    sq.push_back('{1'b1, h + 6});
    sq.push_back('{1'b0, h + 16});
`else
    sq.push_back('{1'b1, h + 2});
    sq.push_back('{1'b0, h + 12});
`endif
    run(10);
    sensor_in = 1'b0;
    run(20);

    // async reset mid-count
    check("pre-reset walk_req", walk_req, 1'b1);
    #2;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("async walk_req", walk_req, 1'b0);
    check("async sensor", sensor, 1'b0);
    check("async tick", tick_1hz, 1'b0);
    tick_next = 10;
    repeat (3) @(negedge clock);
    rst = 1'b1;
    p_walk = 1'b0;
    p_sens = 1'b0;
    mon_en = 1'b1;
    run(25);
    mon_en = 1'b0;

    total++;
    if (tq.size() != 0) begin
      bad++;
      $display("FAIL tick missing: %0d left, next %0d",
               tq.size(), tq[0]);
    end
    total++;
    if (wq.size() != 0) begin
      bad++;
      $display("FAIL walk_req missing: %0d left, next %0d",
               wq.size(), wq[0].c);
    end
    total++;
    if (sq.size() != 0) begin
      bad++;
      $display("FAIL sensor missing: %0d left, next %0d",
               sq.size(), sq[0].c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_input_cond.md
# traffic_input_cond

Input conditioning stage directly upstream of `fsm_traffic`. It synchronizes and debounces the raw pedestrian button and side-street vehicle sensor. It latches pedestrian requests until the controller acknowledges them, and generates the one-cycle-wide 1 Hz enable tick that paces the controller's timing. All outputs are registered and feed `fsm_traffic` directly.

## Interface

Parameters:
- `TICK_DIV`, default 100_000_000: clock cycles per `tick_1hz` pulse. Must be ≥ 2.
- `DB_CYCLES`, default 500_000: consecutive stable cycles required to accept an input change. Must be ≥ 1.

Ports (name, direction, width, meaning):
- `clock` in 1: system clock; all state is clocked on the rising edge.
- `rst` in 1: asynchronous, active-low reset. Asserting it clears all state immediately; release is synchronous to `clock` by the system.
- `walk_btn` in 1: raw, asynchronous, bouncing pedestrian button; high = pressed.
- `sensor_in` in 1: raw, asynchronous vehicle sensor; high = vehicle present.
- `walk_ack` in 1: from `fsm_traffic`; a one-cycle pulse meaning the walk request has been served.
- `walk_req` out 1: latched pedestrian request; drives `fsm_traffic.walk`.
- `sensor` out 1: conditioned sensor level; drives `fsm_traffic.sensor`.
- `tick_1hz` out 1: one-cycle enable pulse every `TICK_DIV` cycles.

## Operation

- **Synchronizer:** `walk_btn` and `sensor_in` each pass through a 2-flop synchronizer (`*_s1` then `*_s2`).
- **Debounce, per input:**
  - State is a stable bit `*_db` and a counter `*_cnt` of width `$clog2(DB_CYCLES)`, minimum 1.
  - When `*_s2 == *_db`, the counter is cleared to 0.
  - When `*_s2 != *_db` and the counter is below `DB_CYCLES-1`, the counter increments.
  - When `*_s2 != *_db` and the counter equals `DB_CYCLES-1`, `*_db` is loaded with `*_s2` and the counter is cleared.
  - Any glitch shorter than `DB_CYCLES` cycles is ignored.
- **Sensor output:** `sensor` equals `sensor_db`.
- **Walk request latch:**
  - A rising-edge detector on `walk_db` (registered previous value `walk_db_q`) produces `walk_rise = walk_db & ~walk_db_q`.
  - Next-state rule: `walk_req <= walk_rise | (walk_req & ~walk_ack)`.
  - If `walk_rise` and `walk_ack` occur in the same cycle, the set wins and the new press is never lost.
  - Holding the button does not re-arm the request after an ack; only a fresh debounced rising edge does.
- **Tick generator:**
  - Counter `tick_cnt`, width `$clog2(TICK_DIV)`, counts 0 to `TICK_DIV-1` and wraps to 0.
  - `tick_1hz` is registered high for exactly the one cycle following the cycle in which `tick_cnt == TICK_DIV-1`.
  - The tick runs freely and is independent of the inputs.

## Timing

- **Reset values:** `walk_req` = 0, `sensor` = 0, `tick_1hz` = 0. All synchronizer flops, stable bits, `walk_db_q` and counters are 0.
- **Debounce latency:** an input held constant after a change at edge N is reflected on `*_db` (and on `sensor`) at edge N+2+`DB_CYCLES`.
- **Request latency:** `walk_req` rises one cycle after `walk_db`, i.e. at edge N+3+`DB_CYCLES`.
- **Ack latency:** `walk_ack` high at edge M clears `walk_req` at edge M (registered); the output is low in the following cycle.
- **First tick:** the first `tick_1hz` is high in cycle `TICK_DIV` after reset release. After that, the tick period is exactly `TICK_DIV` cycles.
- **Reset mid-operation:** any pending request is dropped, the debounce counters clear, and the tick phase restarts. Outputs go to 0 asynchronously, without waiting for a clock edge.
- **Counter behaviour:** the debounce counters never exceed `DB_CYCLES-1`. There is no overflow or wrap other than the specified tick wrap.

## Configuration

- Macro: `SENSOR_DEBOUNCE_EN`.
- **Defined:** the sensor path is debounced exactly as above. Latency is 2+`DB_CYCLES` cycles.
- **Undefined:**
  - `sensor` equals `sensor_s2`; the sensor debounce counter and stable bit are not built.
  - Latency is 2 cycles and glitches pass through.
  - The walk path is debounced in both configurations.

## Test plan

All scenarios use `TICK_DIV`=10 and `DB_CYCLES`=4.
- **Idle after reset:** inputs 0, then `rst` is released → `tick_1hz` high only in cycles 10, 20 and 30; `walk_req` = 0 and `sensor` = 0 throughout.
- **Bounce rejection:** toggle `walk_btn` 1/0 with 2-cycle pulses for 12 cycles, then hold it high → no `walk_req` during bouncing. `walk_req` rises exactly 7 cycles after the final rising edge (2+4+1).
- **Ack and re-arm:**
  - Pulse `walk_ack` while the button is still held → `walk_req` goes low the next cycle and stays low.
  - Release the button for ≥6 cycles, then press and hold it → `walk_req` rises again 7 cycles after the press.
- **Simultaneous set and ack:** force `walk_ack` high in the same cycle `walk_rise` asserts → `walk_req` = 1 after that edge.
- **Sensor path:** a 2-cycle `sensor_in` glitch passes to `sensor` after 2 cycles when `SENSOR_DEBOUNCE_EN` is undefined, and is absent when it is defined. A 10-cycle high level appears after 6 cycles when the macro is defined.
- **Async reset:** drop `rst` mid-count with `walk_req` = 1 → all outputs 0 before the next clock edge. After release, the first tick occurs at cycle 10.
